// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one memory port between instruction fetch and the data side, tracks load tags, routes returns.
// Latency: request->memory is combinational (0 cycles); memory return->*_resp_valid is 1 cycle (registered).
// Backpressure: *_req_ready only when granted and memory answers with a nonzero tag; requesters hold until ready.
//
// Ports:
//   clock, reset              : system clock, synchronous active-high reset
//   branch_flush_en           : front-end redirect; blocks I grants, marks in-flight I loads stale
//   icache_req_* / dcache_req_*: requester command channels (valid/ready)
//   proc2mem_* / mem2proc_*    : single-ported memory bus (command out, accept tag and return tag in)
//   icache_resp_* / dcache_resp_*: one-cycle pulses carrying returned load data to the owner
module fetch_mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int NUM_TAGS     = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            branch_flush_en,
   input  logic            icache_req_valid,
   input  logic [XLEN-1:0] icache_req_addr,
   output logic            icache_req_ready,
   input  logic            dcache_req_valid,
   input  logic [1:0]      dcache_req_cmd,
   input  logic [XLEN-1:0] dcache_req_addr,
   input  logic [63:0]     dcache_req_data,
   output logic            dcache_req_ready,
   output logic [1:0]      proc2mem_command,
   output logic [XLEN-1:0] proc2mem_addr,
   output logic [63:0]     proc2mem_data,
   input  logic [3:0]      mem2proc_response,
   input  logic [63:0]     mem2proc_data,
   input  logic [3:0]      mem2proc_tag,
   output logic            icache_resp_valid,
   output logic [XLEN-1:0] icache_resp_addr,
   output logic [63:0]     icache_resp_data,
   output logic            dcache_resp_valid,
   output logic [XLEN-1:0] dcache_resp_addr,
   output logic [63:0]     dcache_resp_data
);

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;
   localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

   typedef struct packed {
      logic            vld;
      logic            own_i;
      logic [XLEN-1:0] addr;
      logic            discard;
   } tag_entry_t;

   // Entry 0 exists only so a 4-bit tag indexes directly; it is never written valid.
   tag_entry_t tag_tbl [0:NUM_TAGS];

   logic [CW-1:0] starve_cnt;
   logic          starve_at_limit;
   logic          d_req;
   logic          i_elig;
   logic          grant_i;
   logic          grant_d;
   logic          mem_acc;
   logic          i_acc;
   logic          d_acc;
   logic          load_acc;
   tag_entry_t    ret_ent;
   logic          ret_hit;
   logic          i_resp_vld_q;

   assign starve_at_limit = (starve_cnt == CW'(STARVE_LIMIT));

   // Data side wins by default; instruction side wins when data is idle or has been starved long enough.
   always_comb begin
      d_req   = dcache_req_valid && ((dcache_req_cmd == CMD_LOAD) || (dcache_req_cmd == CMD_STORE));
      i_elig  = icache_req_valid && !branch_flush_en;
      grant_i = i_elig && (!d_req || starve_at_limit);
      grant_d = d_req && !grant_i;
   end

   always_comb begin
      proc2mem_command = CMD_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (grant_i) begin
         proc2mem_command = CMD_LOAD;
         proc2mem_addr    = icache_req_addr;
      end else if (grant_d) begin
         proc2mem_command = dcache_req_cmd;
         proc2mem_addr    = dcache_req_addr;
         if (dcache_req_cmd == CMD_STORE) begin
            proc2mem_data = dcache_req_data;
         end
      end
   end

   assign mem_acc          = (mem2proc_response != 4'd0);
   assign i_acc            = grant_i && mem_acc;
   assign d_acc            = grant_d && mem_acc;
   assign icache_req_ready = i_acc;
   assign dcache_req_ready = d_acc;
   assign load_acc         = i_acc || (d_acc && (dcache_req_cmd == CMD_LOAD));

   assign ret_ent = tag_tbl[mem2proc_tag];
   assign ret_hit = (mem2proc_tag != 4'd0) && ret_ent.vld;

   // A flush arriving while the registered I response is on the bus still squashes it.
   assign icache_resp_valid = i_resp_vld_q && !branch_flush_en;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int t = 0; t <= NUM_TAGS; t++) begin
            tag_tbl[t] <= '0;
         end
         starve_cnt        <= '0;
         i_resp_vld_q      <= 1'b0;
         icache_resp_addr  <= '0;
         icache_resp_data  <= '0;
         dcache_resp_valid <= 1'b0;
         dcache_resp_addr  <= '0;
         dcache_resp_data  <= '0;
      end else begin
         for (int t = 1; t <= NUM_TAGS; t++) begin
            if (branch_flush_en && tag_tbl[t].vld && tag_tbl[t].own_i) begin
               tag_tbl[t].discard <= 1'b1;
            end
         end
         if (ret_hit) begin
            tag_tbl[mem2proc_tag].vld <= 1'b0;
         end
         // Placed after the return clear so a same-cycle reuse of the tag keeps the new load.
         if (load_acc) begin
            tag_tbl[mem2proc_response] <= '{vld: 1'b1, own_i: i_acc, addr: proc2mem_addr, discard: 1'b0};
         end

         dcache_resp_valid <= ret_hit && !ret_ent.own_i;
         if (ret_hit && !ret_ent.own_i) begin
            dcache_resp_addr <= ret_ent.addr;
            dcache_resp_data <= mem2proc_data;
         end

         // A flush coinciding with the return also counts as making the load stale.
         i_resp_vld_q <= ret_hit && ret_ent.own_i && !ret_ent.discard && !branch_flush_en;
         if (ret_hit && ret_ent.own_i) begin
            icache_resp_addr <= ret_ent.addr;
            icache_resp_data <= mem2proc_data;
         end

         if (!icache_req_valid || i_acc) begin
            starve_cnt <= '0;
         end else if (d_acc && !branch_flush_en && !starve_at_limit) begin
            starve_cnt <= starve_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb_fetch_mem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change at the falling edge; all outputs are sampled 1 time unit later.
// The memory side is a random responder that may reject, reuse tags or return unknown tags.
module tb_fetch_mem_arbiter;
   localparam int XLEN = 32;

   logic            clock = 1'b0;
   logic            reset;
   logic            branch_flush_en;
   logic            icache_req_valid;
   logic [XLEN-1:0] icache_req_addr;
   logic            icache_req_ready;
   logic            dcache_req_valid;
   logic [1:0]      dcache_req_cmd;
   logic [XLEN-1:0] dcache_req_addr;
   logic [63:0]     dcache_req_data;
   logic            dcache_req_ready;
   logic [1:0]      proc2mem_command;
   logic [XLEN-1:0] proc2mem_addr;
   logic [63:0]     proc2mem_data;
   logic [3:0]      mem2proc_response;
   logic [63:0]     mem2proc_data;
   logic [3:0]      mem2proc_tag;
   logic            icache_resp_valid;
   logic [XLEN-1:0] icache_resp_addr;
   logic [63:0]     icache_resp_data;
   logic            dcache_resp_valid;
   logic [XLEN-1:0] dcache_resp_addr;
   logic [63:0]     dcache_resp_data;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fetch_mem_arbiter #(.XLEN(XLEN), .NUM_TAGS(15), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset), .branch_flush_en(branch_flush_en),
      .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
      .icache_req_ready(icache_req_ready),
      .dcache_req_valid(dcache_req_valid), .dcache_req_cmd(dcache_req_cmd),
      .dcache_req_addr(dcache_req_addr), .dcache_req_data(dcache_req_data),
      .dcache_req_ready(dcache_req_ready),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag),
      .icache_resp_valid(icache_resp_valid), .icache_resp_addr(icache_resp_addr),
      .icache_resp_data(icache_resp_data),
      .dcache_resp_valid(dcache_resp_valid), .dcache_resp_addr(dcache_resp_addr),
      .dcache_resp_data(dcache_resp_data)
   );

   task automatic idle_inputs();
      branch_flush_en   = 1'b0;
      icache_req_valid  = 1'b0;
      icache_req_addr   = '0;
      dcache_req_valid  = 1'b0;
      dcache_req_cmd    = 2'd0;
      dcache_req_addr   = '0;
      dcache_req_data   = '0;
      mem2proc_response = 4'd0;
      mem2proc_data     = '0;
      mem2proc_tag      = 4'd0;
   endtask

   // Leaves the bench at a falling edge with reset released and inputs idle.
   task automatic reset_dut();
      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #1;
      checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL reset_cmd: got %0d want 0", proc2mem_command); end
      checks++; if (proc2mem_addr !== '0 || proc2mem_data !== '0) begin errors++; $display("FAIL reset_bus: addr %h data %h want 0", proc2mem_addr, proc2mem_data); end
      checks++; if (icache_req_ready !== 1'b0 || dcache_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: i %b d %b want 0", icache_req_ready, dcache_req_ready); end
      checks++; if (icache_resp_valid !== 1'b0 || dcache_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_vld: i %b d %b want 0", icache_resp_valid, dcache_resp_valid); end
      checks++; if (icache_resp_addr !== '0 || icache_resp_data !== '0 || dcache_resp_addr !== '0 || dcache_resp_data !== '0) begin
         errors++; $display("FAIL reset_resp_dat: ia %h id %h da %h dd %h want 0", icache_resp_addr, icache_resp_data, dcache_resp_addr, dcache_resp_data);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_i_only();
      reset_dut();
      icache_req_valid = 1'b1; icache_req_addr = 32'h100; mem2proc_response = 4'd3;
      #1;
      checks++; if (icache_req_ready !== 1'b1) begin errors++; $display("FAIL i_only_ready: got %b want 1", icache_req_ready); end
      checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h100) begin errors++; $display("FAIL i_only_cmd: cmd %0d addr %h want 1/100", proc2mem_command, proc2mem_addr); end
      @(negedge clock);
      icache_req_valid = 1'b0; mem2proc_response = 4'd0;
      for (int c = 1; c < 10; c++) begin
         #1;
         checks++; if (icache_resp_valid !== 1'b0) begin errors++; $display("FAIL i_only_early: cycle %0d got %b want 0", c, icache_resp_valid); end
         @(negedge clock);
      end
      mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0000_0001;
      @(negedge clock);
      mem2proc_tag = 4'd0; mem2proc_data = '0;
      #1;
      checks++; if (icache_resp_valid !== 1'b1) begin errors++; $display("FAIL i_only_vld: got %b want 1", icache_resp_valid); end
      checks++; if (icache_resp_addr !== 32'h100 || icache_resp_data !== 64'hDEAD_BEEF_0000_0001) begin
         errors++; $display("FAIL i_only_dat: addr %h data %h want 100/deadbeef00000001", icache_resp_addr, icache_resp_data);
      end
      checks++; if (dcache_resp_valid !== 1'b0) begin errors++; $display("FAIL i_only_dvld: got %b want 0", dcache_resp_valid); end
      @(negedge clock);
      #1;
      checks++; if (icache_resp_valid !== 1'b0) begin errors++; $display("FAIL i_only_pulse: got %b want 0", icache_resp_valid); end
      @(negedge clock);
   endtask

   task automatic test_fairness();
      bit exp_i;
      reset_dut();
      icache_req_valid = 1'b1; icache_req_addr = 32'h300;
      dcache_req_valid = 1'b1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'h400;
      mem2proc_response = 4'd1;
      for (int k = 0; k < 15; k++) begin
         exp_i = ((k % 5) == 4);
         #1;
         checks++; if (icache_req_ready !== exp_i || dcache_req_ready !== !exp_i) begin
            errors++; $display("FAIL fairness: cycle %0d i %b d %b want i %b d %b", k, icache_req_ready, dcache_req_ready, exp_i, !exp_i);
         end
         @(negedge clock);
      end
      idle_inputs();
      @(negedge clock);
   endtask

   task automatic test_store();
      reset_dut();
      dcache_req_valid = 1'b1; dcache_req_cmd = 2'd2; dcache_req_addr = 32'h200;
      dcache_req_data = 64'h55; mem2proc_response = 4'd5;
      #1;
      checks++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== 32'h200 || proc2mem_data !== 64'h55) begin
         errors++; $display("FAIL store_bus: cmd %0d addr %h data %h want 2/200/55", proc2mem_command, proc2mem_addr, proc2mem_data);
      end
      checks++; if (dcache_req_ready !== 1'b1) begin errors++; $display("FAIL store_ready: got %b want 1", dcache_req_ready); end
      @(negedge clock);
      idle_inputs();
      @(negedge clock);
      mem2proc_tag = 4'd5; mem2proc_data = 64'h1234;
      @(negedge clock);
      mem2proc_tag = 4'd0;
      #1;
      checks++; if (dcache_resp_valid !== 1'b0 || icache_resp_valid !== 1'b0) begin
         errors++; $display("FAIL store_no_resp: d %b i %b want 0", dcache_resp_valid, icache_resp_valid);
      end
      @(negedge clock);
   endtask

   task automatic test_flush();
      reset_dut();
      icache_req_valid = 1'b1; icache_req_addr = 32'h180; mem2proc_response = 4'd7;
      #1;
      checks++; if (icache_req_ready !== 1'b1) begin errors++; $display("FAIL flush_setup: got %b want 1", icache_req_ready); end
      @(negedge clock);
      idle_inputs();
      @(negedge clock);
      branch_flush_en = 1'b1;
      icache_req_valid = 1'b1; icache_req_addr = 32'h500;
      dcache_req_valid = 1'b1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'h600;
      mem2proc_response = 4'd8;
      #1;
      checks++; if (icache_req_ready !== 1'b0 || dcache_req_ready !== 1'b1) begin
         errors++; $display("FAIL flush_grant: i %b d %b want 0/1", icache_req_ready, dcache_req_ready);
      end
      checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h600) begin
         errors++; $display("FAIL flush_bus: cmd %0d addr %h want 1/600", proc2mem_command, proc2mem_addr);
      end
      @(negedge clock);
      idle_inputs();
      @(negedge clock);
      mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
      @(negedge clock);
      mem2proc_tag = 4'd0;
      #1;
      checks++; if (icache_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b want 0", icache_resp_valid); end
      @(negedge clock);
      // Flush in the same cycle as the return.
      icache_req_valid = 1'b1; icache_req_addr = 32'h1C0; mem2proc_response = 4'd6;
      @(negedge clock);
      idle_inputs();
      mem2proc_tag = 4'd6; mem2proc_data = 64'h66; branch_flush_en = 1'b1;
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if (icache_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got %b want 0", icache_resp_valid); end
      @(negedge clock);
      // Flush in the output cycle squashes the pulse combinationally.
      icache_req_valid = 1'b1; icache_req_addr = 32'h1E0; mem2proc_response = 4'd9;
      @(negedge clock);
      idle_inputs();
      mem2proc_tag = 4'd9; mem2proc_data = 64'h99;
      @(negedge clock);
      idle_inputs();
      branch_flush_en = 1'b1;
      #1;
      checks++; if (icache_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_out_squash: got %b want 0", icache_resp_valid); end
      branch_flush_en = 1'b0;
      #1;
      checks++; if (icache_resp_valid !== 1'b1 || icache_resp_addr !== 32'h1E0) begin
         errors++; $display("FAIL flush_out_unsquash: vld %b addr %h want 1/1e0", icache_resp_valid, icache_resp_addr);
      end
      @(negedge clock);
   endtask

   task automatic test_reject();
      int tl [4] = '{1, 3, 15, 2};
      reset_dut();
      dcache_req_valid = 1'b1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'h240;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (dcache_req_ready !== 1'b0) begin errors++; $display("FAIL reject_ready: cycle %0d got %b want 0", c, dcache_req_ready); end
         @(negedge clock);
      end
      mem2proc_response = 4'd2;
      #1;
      checks++; if (dcache_req_ready !== 1'b1) begin errors++; $display("FAIL reject_accept: got %b want 1", dcache_req_ready); end
      @(negedge clock);
      idle_inputs();
      foreach (tl[n]) begin
         mem2proc_tag = 4'(tl[n]); mem2proc_data = 64'hC0DE_0000 + 64'(tl[n]);
         @(negedge clock);
         mem2proc_tag = 4'd0;
         #1;
         checks++; if (dcache_resp_valid !== (tl[n] == 2) || icache_resp_valid !== 1'b0) begin
            errors++; $display("FAIL reject_table: tag %0d d %b i %b want d %b i 0", tl[n], dcache_resp_valid, icache_resp_valid, tl[n] == 2);
         end
         if (tl[n] == 2) begin
            checks++; if (dcache_resp_addr !== 32'h240 || dcache_resp_data !== 64'hC0DE_0002) begin
               errors++; $display("FAIL reject_data: addr %h data %h want 240/c0de0002", dcache_resp_addr, dcache_resp_data);
            end
         end
         @(negedge clock);
      end
   endtask

   task automatic test_tag_reuse();
      reset_dut();
      dcache_req_valid = 1'b1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'h280; mem2proc_response = 4'd4;
      @(negedge clock);
      idle_inputs();
      icache_req_valid = 1'b1; icache_req_addr = 32'h108; mem2proc_response = 4'd4;
      mem2proc_tag = 4'd4; mem2proc_data = 64'hAAA;
      #1;
      checks++; if (icache_req_ready !== 1'b1) begin errors++; $display("FAIL reuse_accept: got %b want 1", icache_req_ready); end
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if (dcache_resp_valid !== 1'b1 || dcache_resp_addr !== 32'h280 || dcache_resp_data !== 64'hAAA || icache_resp_valid !== 1'b0) begin
         errors++; $display("FAIL reuse_d_resp: dv %b da %h dd %h iv %b want 1/280/aaa/0", dcache_resp_valid, dcache_resp_addr, dcache_resp_data, icache_resp_valid);
      end
      @(negedge clock);
      mem2proc_tag = 4'd4; mem2proc_data = 64'hBBB;
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if (icache_resp_valid !== 1'b1 || icache_resp_addr !== 32'h108 || icache_resp_data !== 64'hBBB || dcache_resp_valid !== 1'b0) begin
         errors++; $display("FAIL reuse_i_resp: iv %b ia %h id %h dv %b want 1/108/bbb/0", icache_resp_valid, icache_resp_addr, icache_resp_data, dcache_resp_valid);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_drop();
      reset_dut();
      dcache_req_valid = 1'b1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'h2C0; mem2proc_response = 4'd10;
      @(negedge clock);
      reset_dut();
      mem2proc_tag = 4'd10; mem2proc_data = 64'h10;
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if (dcache_resp_valid !== 1'b0 || icache_resp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_drop: d %b i %b want 0", dcache_resp_valid, icache_resp_valid);
      end
      @(negedge clock);
   endtask

   // Behavioural model: a table of outstanding loads keyed by tag, and a count of
   // consecutive data-side wins while the instruction side was waiting.
   task automatic test_random();
      bit m_v [16]; bit m_i [16]; bit m_dis [16];
      logic [XLEN-1:0] m_a [16];
      int m_st = 0;
      bit e_iv = 0, e_dv = 0;
      logic [XLEN-1:0] e_ia = '0, e_da = '0;
      logic [63:0] e_id = '0, e_dd = '0;
      bit ip = 0, dp = 0;
      logic [XLEN-1:0] ia = '0, da = '0;
      logic [1:0] dc = 2'd0;
      logic [63:0] dd = '0;
      bit d_req, i_ok, i_wins, d_wins, acc, nv_i, nv_d;
      logic [1:0] x_cmd; logic [XLEN-1:0] x_addr; logic [63:0] x_data;
      int t;
      reset_dut();
      for (int u = 0; u < 16; u++) begin m_v[u] = 0; m_i[u] = 0; m_dis[u] = 0; m_a[u] = '0; end
      for (int k = 0; k < 3000; k++) begin
         if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ia = $urandom & 32'hFFFF_FFF8; end
         if (!dp && $urandom_range(0, 2) != 0) begin dp = 1; dc = 2'($urandom_range(0, 3)); da = $urandom; dd = {$urandom, $urandom}; end
         icache_req_valid = ip; icache_req_addr = ia;
         dcache_req_valid = dp; dcache_req_cmd = dc; dcache_req_addr = da; dcache_req_data = dd;
         branch_flush_en = ($urandom_range(0, 9) == 0);
         mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         mem2proc_tag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         mem2proc_data = {$urandom, $urandom};
         reset = ((k % 1000) == 999);
         #1;
         d_req  = dp && (dc == 2'd1 || dc == 2'd2);
         i_ok   = ip && !branch_flush_en;
         i_wins = i_ok && (!d_req || m_st == 4);
         d_wins = d_req && !i_wins;
         acc    = (mem2proc_response != 0);
         x_cmd  = i_wins ? 2'd1 : (d_wins ? dc : 2'd0);
         x_addr = i_wins ? ia : (d_wins ? da : '0);
         x_data = (d_wins && dc == 2'd2) ? dd : '0;
         checks++; if (proc2mem_command !== x_cmd || proc2mem_addr !== x_addr || proc2mem_data !== x_data) begin
            errors++; $display("FAIL rnd_bus: k %0d cmd %0d addr %h data %h want %0d %h %h", k, proc2mem_command, proc2mem_addr, proc2mem_data, x_cmd, x_addr, x_data);
         end
         checks++; if (icache_req_ready !== (i_wins && acc) || dcache_req_ready !== (d_wins && acc)) begin
            errors++; $display("FAIL rnd_ready: k %0d i %b d %b want %b %b", k, icache_req_ready, dcache_req_ready, i_wins && acc, d_wins && acc);
         end
         checks++; if (icache_resp_valid !== (e_iv && !branch_flush_en) || dcache_resp_valid !== e_dv) begin
            errors++; $display("FAIL rnd_resp_vld: k %0d i %b d %b want %b %b", k, icache_resp_valid, dcache_resp_valid, e_iv && !branch_flush_en, e_dv);
         end
         if (e_iv && !branch_flush_en) begin
            checks++; if (icache_resp_addr !== e_ia || icache_resp_data !== e_id) begin
               errors++; $display("FAIL rnd_i_dat: k %0d addr %h data %h want %h %h", k, icache_resp_addr, icache_resp_data, e_ia, e_id);
            end
         end
         if (e_dv) begin
            checks++; if (dcache_resp_addr !== e_da || dcache_resp_data !== e_dd) begin
               errors++; $display("FAIL rnd_d_dat: k %0d addr %h data %h want %h %h", k, dcache_resp_addr, dcache_resp_data, e_da, e_dd);
            end
         end
         if (reset) begin
            for (int u = 0; u < 16; u++) m_v[u] = 0;
            m_st = 0; e_iv = 0; e_dv = 0; ip = 0; dp = 0;
         end else begin
            nv_i = 0; nv_d = 0;
            t = int'(mem2proc_tag);
            if (t != 0 && m_v[t]) begin
               if (!m_i[t]) begin nv_d = 1; e_da = m_a[t]; e_dd = mem2proc_data; end
               else if (!m_dis[t] && !branch_flush_en) begin nv_i = 1; e_ia = m_a[t]; e_id = mem2proc_data; end
               m_v[t] = 0;
            end
            if (branch_flush_en)
               for (int u = 1; u < 16; u++) if (m_v[u] && m_i[u]) m_dis[u] = 1;
            if (acc && (i_wins || (d_wins && dc == 2'd1))) begin
               t = int'(mem2proc_response);
               m_v[t] = 1; m_i[t] = i_wins; m_a[t] = x_addr; m_dis[t] = 0;
            end
            e_iv = nv_i; e_dv = nv_d;
            if (!ip || (i_wins && acc)) m_st = 0;
            else if (d_wins && acc && !branch_flush_en && m_st < 4) m_st++;
            if (i_wins && acc) ip = 0;
            if (branch_flush_en) ip = 0;
            if ((d_wins && acc) || !(dc == 2'd1 || dc == 2'd2)) dp = 0;
         end
         @(negedge clock);
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(negedge clock);
      test_reset();
      test_i_only();
      test_fairness();
      test_store();
      test_flush();
      test_reject();
      test_tag_reuse();
      test_reset_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_mem_arbiter.md
# fetch_mem_arbiter

Shares the single-ported main memory interface between the instruction-side requester (fetch/I-cache miss path) and the data-side requester (D-cache/LSQ). Issues one memory command per cycle, tracks outstanding loads by memory tag, and routes returned data to the owning requester. It also discards in-flight instruction loads made stale by a branch flush. It sits between the fetch/dispatch front end plus the LSQ on one side and the `proc2mem`/`mem2proc` memory bus on the other.

## Interface
- `NUM_TAGS`, 15: memory tag space; tags 1..15 are valid, and 0 means none/rejected.
- `STARVE_LIMIT`, 4: number of consecutive data-side wins that force an instruction-side win.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `branch_flush_en`  in  1  front-end flush; the instruction side is redirected.
- `icache_req_valid`  in  1  instruction load request.
- `icache_req_addr`  in  `XLEN`  8-byte-aligned fetch address.
- `icache_req_ready`  out  1  instruction request accepted by memory this cycle.
- `dcache_req_valid`  in  1  data request.
- `dcache_req_cmd`  in  2  1=LOAD, 2=STORE (0/3 treated as no request).
- `dcache_req_addr`  in  `XLEN`  data address.
- `dcache_req_data`  in  64  store data.
- `dcache_req_ready`  out  1  data request accepted this cycle.
- `proc2mem_command`  out  2  0=NONE, 1=LOAD, 2=STORE.
- `proc2mem_addr`  out  `XLEN`  granted address.
- `proc2mem_data`  out  64  store data (0 unless STORE).
- `mem2proc_response`  in  4  nonzero = request accepted, with tag value.
- `mem2proc_data`  in  64  returned load data.
- `mem2proc_tag`  in  4  nonzero = data for that tag is valid this cycle.
- `icache_resp_valid`  out  1  instruction data valid.
- `icache_resp_addr`  out  `XLEN`  address of the returned line.
- `icache_resp_data`  out  64  returned line.
- `dcache_resp_valid`  out  1  load data valid.
- `dcache_resp_addr`  out  `XLEN`  load address.
- `dcache_resp_data`  out  64  load data.

## Operation
- **Grant (combinational).**
  - Data side wins by default.
  - The instruction side wins if data is idle, or if `starve_cnt == STARVE_LIMIT`.
  - The instruction side is never granted while `branch_flush_en`=1.
  - With no eligible request, command is NONE and addr/data are 0.
- **Accept.** `*_req_ready` = granted & (`mem2proc_response` != 0). Requesters hold their request until ready.
- **Tag table.** Indexed 1..15; each entry holds valid, owner (I/D), addr, discard.
  - On an accepted LOAD, write entry[`mem2proc_response`] = {1, owner, addr, 0}.
  - Accepted STOREs are not tracked.
- **Return.** When `mem2proc_tag` != 0 and entry valid:
  - If owner=D, register the data to the D outputs.
  - If owner=I and discard=0, register the data to the I outputs.
  - Clear the entry in both cases.
  - A return to an invalid entry is ignored.
- **Flush.** When `branch_flush_en`=1, set discard on every valid I-owned entry. This includes an entry returning in the same cycle, which is then suppressed.
- **Starvation counter** (3 bits minimum, saturating at `STARVE_LIMIT`):
  - +1 when `icache_req_valid`, the D side is accepted, and the flush is low.
  - Reset to 0 when the I side is accepted or `icache_req_valid`=0.
  - Otherwise hold.
- **Same-cycle return and accept of the same tag.** Process the return (read/clear) first, then the accept write wins.

## Timing
- Request to memory: 0 cycles (combinational). Ready is in the same cycle as `mem2proc_response`.
- Return to `*_resp_valid`: 1 cycle (registered). Each resp valid is a 1-cycle pulse per return.
- `icache_resp_valid` = registered valid & ~`branch_flush_en`. A flush in the output cycle also squashes the output.
- **Reset values:**
  - All table entries are invalid and `starve_cnt`=0.
  - `icache_resp_valid`/`dcache_resp_valid`=0, with resp addr/data at 0.
  - Memory outputs follow the combinational grant (NONE with no requests).
- Reset mid-operation drops all outstanding tags. Later returns of those tags are ignored.
- At most one command per cycle and at most one return per cycle.

## Test plan
- **Only I-side requesting.**
  - Stimulus: I LOAD `0x100`; response tag 3; tag 3 returns 10 cycles later with data `0xDEAD_BEEF_0000_0001`.
  - Expected: `icache_req_ready`=1 in the accept cycle, then `icache_resp_valid`=1, addr `0x100`, that data, in the cycle after the return. `dcache_resp_valid` stays 0.
- **Both sides requesting every cycle, memory always accepting.**
  - Expected: D granted 4 consecutive cycles, then I granted once, then the counter restarts (pattern D,D,D,D,I repeating).
- **D STORE `0x200` with data `0x55`.**
  - Expected: command=2, data `0x55`, ready=1 with response 5. A later `mem2proc_tag`=5 produces no resp pulse.
- **Flush with an I load outstanding.**
  - Stimulus: I load outstanding on tag 7; flush pulse; tag 7 returns 2 cycles later.
  - Expected: no `icache_resp_valid`. While the flush is high, `icache_req_ready`=0 and the D request is granted.
- **Memory rejects, then accepts.**
  - Stimulus: response=0 for 3 cycles, then tag 2.
  - Expected: ready low for the 3 cycles, then high. The table holds tag 2 only.
- **Tag reuse in one cycle.**
  - Stimulus: tag 4 returns (D-owned) in the same cycle as a new I accept receives tag 4.
  - Expected: D resp fires next cycle. A later return of tag 4 goes to I.
